hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Iterative multiply/divide sequencer that owns the HI/LO register pair for the EX stage.
//  Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO from Ins, runs a 32-step shift-add or restoring-divide loop,
//  and presents HI/LO to the ALU for MFHI/MFLO.
//  Raises stall to the pipeline while any HI/LO-touching instruction would conflict with a running op.
// PARAMETERS
//  XLEN   32  operand and HI/LO width
//  CNT_W  6   iteration counter width; must hold XLEN
// PORTS
//  CLK          in   1     clock; all state updates on posedge
//  RST          in   1     reset; synchronous, active-high
//  issue_valid  in   1     Ins in EX is valid this cycle
//  Ins          in   32    instruction in EX; opcode Ins[31:26], funct Ins[5:0]
//  Rdata1       in   32    rs value (multiplicand / dividend / MTHI-MTLO source)
//  Rdata2       in   32    rt value (multiplier / divisor)
//  stall        out  1     hold EX; Ins/Rdata must stay stable while high
//  busy         out  1     iteration in progress
//  done         out  1     one-cycle pulse: new HI/LO visible this cycle
//  HIreg        out  32    HI register (mult high word / div remainder)
//  LOreg        out  32    LO register (mult low word / div quotient)
// BEHAVIOUR
//  Decode: opcode 6'h00 and funct MFHI 10, MTHI 11, MFLO 12, MTLO 13, MULT 18, MULTU 19, DIV 1A, DIVU 1B (hex).
//  Reset: state=IDLE, busy=0, done=0, stall=0, HIreg=LOreg=0, counter=0. RST mid-op aborts; no HI/LO write.
//  States: IDLE -> MUL|DIV on accept; MUL|DIV -> SIGN when counter reaches XLEN-1; SIGN -> IDLE.
//  Accept: issue_valid & mul/div funct & state==IDLE. Latch |operands| (signed ops) or raw (unsigned) and sign flags.
//  Latency: accept cycle C; 32 iteration cycles C+1..C+32; SIGN at C+33; HI/LO written at end of C+33;
//   done=1 in C+34. Fixed for all four ops, incl. unsigned and divide-by-zero.
//  busy=1 from C+1 through C+33 inclusive; 0 in IDLE.
//  Multiply: 64-bit product, shift-add one bit/cycle. Signed: negate 64-bit result if operand signs differ.
//  Divide: restoring, one quotient bit/cycle. Signed: quotient negated if signs differ;
//   remainder takes the dividend's sign. 0x80000000 / -1 -> LO=0x80000000, HI=0.
//  Divide by zero (Rdata2==0): HI=Rdata1 as latched at accept, LO=32'hFFFFFFFF, signed or unsigned.
//  MTHI/MTLO in IDLE: write Rdata1 to HI/LO at end of the issue cycle; no busy, no done.
//  stall = issue_valid & busy & Ins is any of the 8 HI/LO functs above; other instructions never stall.
//  Stalled instruction proceeds in C+34 (busy=0): MFHI/MFLO see the new result; a new mul/div is accepted then.
//  A mul/div issued in the SIGN cycle stalls; MTHI/MTLO never overwrite a pending result.
//  HIreg/LOreg are registered outputs; they change only at SIGN completion, MTHI/MTLO, or RST.
//  Non-R-form opcodes and other functts: no effect, no stall.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 33 cycles, done at C+34, HI=0xFFFFFFFE, LO=0x00000001.
//  MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//  DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  DIVU 5/0 -> HI=5, LO=0xFFFFFFFF at C+34; DIV -5/0 -> HI=0xFFFFFFFB, LO=0xFFFFFFFF.
//  MULT 6*7 then MFHI held valid from C+3 -> stall=1 C+3..C+33, 0 at C+34, HIreg=0, LOreg=42 when released.
//  RST at C+10 of DIVU -> next cycle busy=0, HI=LO=0, no done; MTLO 0x1234 next -> LO=0x1234, stall=0.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply/divide unit.
// An HI/LO instruction is taken when issue_valid is high and stall is low at a rising edge.
// While stall is high, the pipeline keeps issue_valid, Ins and the Rdata values stable.
interface hilo_muldiv_ctrl_if #(parameter int XLEN = 32);
  logic            issue_valid;
  logic [31:0]     Ins;
  logic [XLEN-1:0] Rdata1;
  logic [XLEN-1:0] Rdata2;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] HIreg;
  logic [XLEN-1:0] LOreg;

  modport master (output issue_valid, Ins, Rdata1, Rdata2,
                  input  stall, busy, done, HIreg, LOreg);
  modport slave  (input  issue_valid, Ins, Rdata1, Rdata2,
                  output stall, busy, done, HIreg, LOreg);
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO: one bit per cycle,
// followed by a single sign-fixup cycle that commits the result.
module hilo_muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  hilo_muldiv_ctrl_if.slave bus,
  output logic [1:0]        dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, SIGN = 2'd3} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*XLEN:0]  acc;
  logic [XLEN-1:0]  opnd;
  logic [XLEN-1:0]  dividend_raw;
  logic             op_div, div_zero, neg_q, neg_r;

  logic [5:0] funct;
  logic       is_r, is_muldiv, is_hilo, is_mthi, is_mtlo, accept, signed_op;
  logic       sa, sb;
  logic [XLEN-1:0] ma, mb;
  logic [XLEN:0]   mul_sum, div_diff;
  logic [2*XLEN:0] mul_next, div_shift, div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] hi_fin, lo_fin, quo, rem;
  logic unused_ins;

  assign unused_ins = &{1'b0, bus.Ins[25:6]};
  assign funct      = bus.Ins[5:0];
  assign is_r       = (bus.Ins[31:26] == 6'h00);
  assign is_muldiv  = is_r && (funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
  assign is_hilo    = is_muldiv || (is_r && (funct inside {6'h10, 6'h11, 6'h12, 6'h13}));
  assign is_mthi    = is_r && (funct == 6'h11);
  assign is_mtlo    = is_r && (funct == 6'h13);
  assign accept     = bus.issue_valid && is_muldiv && (state == IDLE);
  assign dbg_state  = state;

  // Signed ops iterate on magnitudes; signs are reapplied in the SIGN cycle.
  always_comb begin
    signed_op = ~funct[0];
    sa = signed_op & bus.Rdata1[XLEN-1];
    sb = signed_op & bus.Rdata2[XLEN-1];
    ma = sa ? -bus.Rdata1 : bus.Rdata1;
    mb = sb ? -bus.Rdata2 : bus.Rdata2;
  end

  always_comb begin
    mul_sum   = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {1'b0, mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:0], 1'b0};
    div_diff  = div_shift[2*XLEN:XLEN] - {1'b0, opnd};
    div_next  = div_diff[XLEN] ? div_shift : {div_diff, div_shift[XLEN-1:1], 1'b1};
  end

  always_comb begin
    prod = neg_q ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!op_div) begin
      hi_fin = prod[2*XLEN-1:XLEN];
      lo_fin = prod[XLEN-1:0];
    end else if (div_zero) begin
      hi_fin = dividend_raw;
      lo_fin = '1;
    end else begin
      hi_fin = rem;
      lo_fin = quo;
    end
  end

  always_comb begin
    state_nx  = state;
    bus.busy  = (state != IDLE);
    bus.stall = bus.issue_valid && (state != IDLE) && is_hilo;
    case (state)
      IDLE:    if (accept) state_nx = funct[1] ? DIV : MUL;
      MUL,
      DIV:     if (cnt == CNT_W'(XLEN-1)) state_nx = SIGN;
      SIGN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0; acc <= '0; opnd <= '0; dividend_raw <= '0;
      op_div <= 1'b0; div_zero <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0;
      bus.done <= 1'b0; bus.HIreg <= '0; bus.LOreg <= '0;
    end else begin
      bus.done <= (state == SIGN);
      case (state)
        IDLE: begin
          if (accept) begin
            cnt          <= '0;
            op_div       <= funct[1];
            neg_q        <= sa ^ sb;
            neg_r        <= sa;
            dividend_raw <= bus.Rdata1;
            div_zero     <= (bus.Rdata2 == '0);
            acc          <= {{(XLEN+1){1'b0}}, funct[1] ? ma : mb};
            opnd         <= funct[1] ? mb : ma;
          end else if (bus.issue_valid && is_mthi) begin
            bus.HIreg <= bus.Rdata1;
          end else if (bus.issue_valid && is_mtlo) begin
            bus.LOreg <= bus.Rdata1;
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
        end
        SIGN: begin
          bus.HIreg <= hi_fin;
          bus.LOreg <= lo_fin;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed corner cases, randomized
// mul/div against an arithmetic reference, stall and reset-abort behaviour.
module tb_hilo_muldiv_ctrl;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;
  int tests = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  hilo_muldiv_ctrl_if bus();
  hilo_muldiv_ctrl dut (.CLK(clk), .RST(rst), .bus(bus), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] f);
    return {6'h00, 20'h0, f};
  endfunction

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like DIV.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      F_MULT:  return sa * sb;
      F_MULTU: return ua * ub;
      F_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.Ins = r_ins(f);
    bus.Rdata1 = a;
    bus.Rdata2 = b;
    @(posedge clk);
    #1 bus.issue_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int busy_cnt, done_cnt, done_at;
    logic [63:0] got, want;
    busy_cnt = 0; done_cnt = 0; done_at = 0; got = '0;
    exp_q.push_back(exp);
    issue(f, a, b);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k;
          got = {bus.HIreg, bus.LOreg};
        end
      end
    end
    want = exp_q.pop_front();
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, "_done_at"}, 64'(done_at), 64'd34);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_hilo"}, got, want);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int stall_cnt, release_at, done_cnt;
    logic [31:0] a, b;
    logic [5:0] f;
    logic [63:0] rel_hilo;
    bus.issue_valid = 1'b0;
    bus.Ins = '0;
    bus.Rdata1 = '0;
    bus.Rdata2 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'h0, bus.busy}, 64'd0);
    check("reset_done", {63'h0, bus.done}, 64'd0);
    check("reset_hilo", {bus.HIreg, bus.LOreg}, 64'h0);
    rst = 1'b0;

    issue(F_MTHI, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    check("mthi_hi", {32'h0, bus.HIreg}, {32'h0, 32'hDEAD_BEEF});
    check("mthi_no_busy", {63'h0, bus.busy}, 64'd0);
    issue(F_MTLO, 32'h0BAD_F00D, 32'h0);
    @(negedge clk);
    check("mtlo_lo", {32'h0, bus.LOreg}, {32'h0, 32'h0BAD_F00D});
    check("mtlo_no_done", {63'h0, bus.done}, 64'd0);

    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_m3x7", F_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mult_min2", F_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("div_m7d2", F_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_100d7", F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("divu_by0", F_DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
    run_op("div_by0", F_DIV, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);

    // MFHI held in EX while MULT 6*7 runs.
    issue(F_MULT, 32'd6, 32'd7);
    stall_cnt = 0; release_at = 0; rel_hilo = '0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 3) begin
        bus.issue_valid = 1'b1;
        bus.Ins = r_ins(F_MFHI);
      end
      #1;
      if (k >= 3 && bus.stall) stall_cnt++;
      if (k >= 3 && !bus.stall && release_at == 0) begin
        release_at = k;
        rel_hilo = {bus.HIreg, bus.LOreg};
      end
    end
    @(posedge clk);
    #1 bus.issue_valid = 1'b0;
    check("mfhi_stall_cycles", 64'(stall_cnt), 64'd31);
    check("mfhi_release_at", 64'(release_at), 64'd34);
    check("mfhi_release_hilo", rel_hilo, 64'd42);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
      run_op($sformatf("rand%0d", i), f, a, b, model(f, a, b));
    end

    // DIVU interrupted by reset; non-HI/LO instructions must never stall.
    issue(F_DIVU, 32'd1000, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 5) begin
        bus.issue_valid = 1'b1;
        bus.Ins = r_ins(6'h20);
        #1 check("add_no_stall", {63'h0, bus.stall}, 64'd0);
        bus.Ins = {6'h23, 20'h0, F_MULT};
        #1 check("iform_no_stall", {63'h0, bus.stall}, 64'd0);
        bus.Ins = r_ins(F_MTHI);
        #1 check("mthi_busy_stall", {63'h0, bus.stall}, 64'd1);
        bus.Ins = r_ins(F_MULTU);
        #1 check("mul_busy_stall", {63'h0, bus.stall}, 64'd1);
        bus.issue_valid = 1'b0;
      end
      if (k == 10) rst = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'h0, bus.busy}, 64'd0);
    check("abort_done", {63'h0, bus.done}, 64'd0);
    check("abort_hilo", {bus.HIreg, bus.LOreg}, 64'h0);
    bus.issue_valid = 1'b1;
    bus.Ins = r_ins(F_MTLO);
    bus.Rdata1 = 32'h1234;
    #1 check("abort_mtlo_stall", {63'h0, bus.stall}, 64'd0);
    @(posedge clk);
    #1 bus.issue_valid = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) check("abort_mtlo_lo", {bus.HIreg, bus.LOreg}, 64'h1234);
      if (bus.done || bus.busy) done_cnt++;
    end
    check("abort_quiet", 64'(done_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
